// File: rtl/icache_lookup_fill.sv
// Direct-mapped I-cache data stage: tag lookup, line fill over req/gnt/rvalid, AHB read response.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_lookup_fill #(
   parameter int NUM_LINES = 16,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] read_addr,
   input  logic [1:0]        trans_in,
   input  logic [3:0]        read_addr_offset,
   output logic [31:0]       hrdata,
   output logic              hready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 4 - IDX_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_REQ    = 3'd2,
      S_FILL   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [31:0]             r_hrdata;
   logic                    r_hready;
   logic                    r_mem_req;
   logic [ADDR_W-1:0]       r_mem_addr;
   logic [IDX_W-1:0]        r_idx;
   logic [TAG_W-1:0]        r_tag;
   logic [1:0]              r_word;
   logic [1:0]              r_beat_cnt;
   logic [NUM_LINES-1:0]    r_valid;
   logic [TAG_W-1:0]        r_tag_arr [NUM_LINES];
   logic [31:0]             r_data    [NUM_LINES][4];

   logic                    w_accept;
   logic [IDX_W-1:0]        w_idx;
   logic [TAG_W-1:0]        w_tag;
   logic [1:0]              w_word;
   logic                    w_hit;
   logic                    w_lookup_hit;
   logic                    w_lookup_miss;
   logic                    w_fill_beat;
   logic                    w_fill_last;
   logic                    w_unused;

   // NONSEQ and SEQ are the only transfer types with bit 1 set
   assign w_accept      = r_hready && trans_in[1];
   assign w_idx         = read_addr[4+IDX_W-1:4];
   assign w_tag         = read_addr[ADDR_W-1:4+IDX_W];
   assign w_word        = read_addr_offset[3:2];
   assign w_hit         = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
   assign w_lookup_hit  = w_accept && w_hit;
   assign w_lookup_miss = w_accept && !w_hit;
   assign w_fill_beat   = (r_state == S_FILL) && mem_rvalid;
   assign w_fill_last   = w_fill_beat && (r_beat_cnt == 2'd3);
   assign w_unused      = ^{read_addr_offset[1:0], read_addr[3:0]};

   assign hrdata   = r_hrdata;
   assign hready   = r_hready;
   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_LOOKUP, S_RESP: begin
            if (w_accept) w_next = w_hit ? S_LOOKUP : S_REQ;
            else          w_next = S_IDLE;
         end
         S_REQ:   if (mem_gnt)     w_next = S_FILL;
         S_FILL:  if (w_fill_last) w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_hrdata   <= '0;
         r_hready   <= 1'b1;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_idx      <= '0;
         r_tag      <= '0;
         r_word     <= '0;
         r_beat_cnt <= '0;
         r_valid    <= '0;
      end else begin
         r_state <= w_next;
         if (w_lookup_hit) begin
            r_hrdata <= r_data[w_idx][w_word];
            r_hready <= 1'b1;
         end
         // A miss evicts the resident line right away so a partial fill never reads as valid
         if (w_lookup_miss) begin
            r_hready        <= 1'b0;
            r_mem_req       <= 1'b1;
            r_mem_addr      <= {read_addr[ADDR_W-1:4], 4'b0000};
            r_idx           <= w_idx;
            r_tag           <= w_tag;
            r_word          <= w_word;
            r_beat_cnt      <= '0;
            r_valid[w_idx]  <= 1'b0;
         end
         if ((r_state == S_REQ) && mem_gnt) r_mem_req <= 1'b0;
         if (w_fill_beat) r_beat_cnt <= r_beat_cnt + 2'd1;
         // Word 3 arrives on the final beat and is not in the array yet, so bypass it
         if (w_fill_last) begin
            r_valid[r_idx] <= 1'b1;
            r_hready       <= 1'b1;
            r_hrdata       <= (r_word == 2'd3) ? mem_rdata : r_data[r_idx][r_word];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_beat) r_data[r_idx][r_beat_cnt] <= mem_rdata;
      if (w_fill_last) r_tag_arr[r_idx] <= r_tag;
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_lookup_hit  && (r_hit_cnt  != 32'hFFFF_FFFF)) r_hit_cnt  <= r_hit_cnt  + 32'd1;
         if (w_lookup_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_lookup_fill.sv
// Directed bench for icache_lookup_fill: hit vector table plus hand-written miss/fill/reset sequences.
module tb_icache_lookup_fill;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] read_addr = '0;
   logic [1:0]  trans_in = 2'd0;
   logic [3:0]  read_addr_offset = '0;
   logic [31:0] hrdata;
   logic        hready;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   icache_lookup_fill dut (
      .clk(clk), .rstn(rstn), .read_addr(read_addr), .trans_in(trans_in),
      .read_addr_offset(read_addr_offset), .hrdata(hrdata), .hready(hready),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
      , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  tr;
      logic [31:0] addr;
      logic        exp_rdy;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vt [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] tr, input logic [31:0] addr);
      trans_in         = tr;
      read_addr        = addr;
      read_addr_offset = addr[3:0];
      tick();
      trans_in         = 2'd0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         trans_in         = vt[i].tr;
         read_addr        = vt[i].addr;
         read_addr_offset = vt[i].addr[3:0];
         tick();
         chk($sformatf("vec%0d_hready", i), {31'b0, hready}, {31'b0, vt[i].exp_rdy});
         chk($sformatf("vec%0d_hrdata", i), hrdata, vt[i].exp_data);
         chk($sformatf("vec%0d_no_req", i), {31'b0, mem_req}, 32'd0);
      end
      trans_in = 2'd0;
   endtask

   // Grant after gnt_wait REQ cycles, then four beats d0..d0+3 separated by gap idle cycles
   task automatic do_fill(input logic [31:0] base, input logic [31:0] d0, input int gnt_wait,
                          input bit spurious, input int gap);
      for (int i = 0; i < gnt_wait; i++) begin
         chk($sformatf("req_hold%0d", i), {31'b0, mem_req}, 32'd1);
         chk($sformatf("addr_hold%0d", i), mem_addr, base);
         mem_rvalid = spurious;
         mem_rdata  = 32'hDEAD_BEEF;
         tick();
      end
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("req_drop_after_gnt", {31'b0, mem_req}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = d0 + k;
         tick();
         mem_rvalid = 1'b0;
         if (k < 3) begin
            chk($sformatf("fill_stall_b%0d", k), {31'b0, hready}, 32'd0);
            repeat (gap) tick();
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{2'd2, 32'h108, 1'b1, 32'hA2};
      vt[1] = '{2'd3, 32'h10C, 1'b1, 32'hA3};
      vt[2] = '{2'd3, 32'h100, 1'b1, 32'hA0};
      vt[3] = '{2'd3, 32'h104, 1'b1, 32'hA1};
      vt[4] = '{2'd0, 32'h7F0, 1'b1, 32'hA1};
      vt[5] = '{2'd1, 32'h7F0, 1'b1, 32'hA1};
      vt[6] = '{2'd2, 32'h340, 1'b1, 32'hD0};
      vt[7] = '{2'd3, 32'h344, 1'b1, 32'hD1};
      vt[8] = '{2'd3, 32'h348, 1'b1, 32'hD2};
      vt[9] = '{2'd3, 32'h34C, 1'b1, 32'hD3};

      // Reset state
      repeat (2) tick();
      chk("rst_hready", {31'b0, hready}, 32'd1);
      chk("rst_hrdata", hrdata, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      rstn = 1'b1;
      tick();

      // Cold miss on 0x100 and fill
      issue(2'd2, 32'h100);
      chk("t1_miss_hready", {31'b0, hready}, 32'd0);
      chk("t1_mem_req", {31'b0, mem_req}, 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h100);
      do_fill(32'h100, 32'hA0, 1, 1'b0, 0);
      chk("t1_resp_hready", {31'b0, hready}, 32'd1);
      chk("t1_resp_hrdata", hrdata, 32'hA0);
      tick();

      // WRAP4 hits back to back, then IDLE/BUSY hold
      run_vecs(0, 5);

      // Conflict at index 0: 0x200 evicts 0x100, re-read of 0x100 misses again
      issue(2'd2, 32'h204);
      chk("t3_miss200_hready", {31'b0, hready}, 32'd0);
      chk("t3_miss200_addr", mem_addr, 32'h200);
      do_fill(32'h200, 32'hB0, 0, 1'b0, 0);
      chk("t3_resp200", hrdata, 32'hB1);
      issue(2'd2, 32'h10C);
      chk("t3_miss100_hready", {31'b0, hready}, 32'd0);
      chk("t3_miss100_addr", mem_addr, 32'h100);
      do_fill(32'h100, 32'hC0, 2, 1'b0, 0);
      chk("t3_resp100_word3", hrdata, 32'hC3);
      tick();
`ifdef ICACHE_STATS_EN
      chk("stats_miss", miss_cnt, 32'd3);
      chk("stats_hit", hit_cnt, 32'd4);
`endif

      // Spurious rvalid while idle must not disturb the array
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      repeat (2) tick();
      mem_rvalid = 1'b0;
      issue(2'd2, 32'h100);
      chk("t4_idle_rvalid_hit", hrdata, 32'hC0);
      chk("t4_idle_rvalid_rdy", {31'b0, hready}, 32'd1);

      // Grant held off 5 cycles with spurious rvalid in REQ, gapped beats
      issue(2'd2, 32'h348);
      chk("t4_miss_hready", {31'b0, hready}, 32'd0);
      do_fill(32'h340, 32'hD0, 5, 1'b1, 2);
      chk("t4_resp_hready", {31'b0, hready}, 32'd1);
      chk("t4_resp_hrdata", hrdata, 32'hD2);
      tick();
      run_vecs(6, 9);

      // Reset while in REQ drops mem_req at once
      issue(2'd2, 32'h700);
      chk("t5_req_before_rst", {31'b0, mem_req}, 32'd1);
      rstn = 1'b0;
      #1;
      chk("t5_req_async_drop", {31'b0, mem_req}, 32'd0);
      tick();
      rstn = 1'b1;
      tick();

      // Reset after fill beat 2, then refill shows no stale data
      issue(2'd2, 32'h504);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hE0 + k;
         tick();
      end
      mem_rvalid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("t5_rst_hready", {31'b0, hready}, 32'd1);
      chk("t5_rst_hrdata", hrdata, 32'd0);
      chk("t5_rst_mem_req", {31'b0, mem_req}, 32'd0);
      tick();
      rstn = 1'b1;
      tick();
      issue(2'd2, 32'h504);
      chk("t5_refill_miss", {31'b0, hready}, 32'd0);
      chk("t5_refill_addr", mem_addr, 32'h500);
      do_fill(32'h500, 32'hF0, 1, 1'b0, 0);
      chk("t5_refill_resp", hrdata, 32'hF1);
      issue(2'd2, 32'h508);
      chk("t5_hit_no_stale", hrdata, 32'hF2);
      chk("t5_hit_hready", {31'b0, hready}, 32'd1);

`ifdef ICACHE_STATS_EN
      tick();
      force dut.r_hit_cnt = 32'hFFFF_FFFF;
      tick();
      release dut.r_hit_cnt;
      issue(2'd2, 32'h500);
      chk("stats_sat_hrdata", hrdata, 32'hF0);
      chk("stats_hit_saturate", hit_cnt, 32'hFFFF_FFFF);
`endif

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
